vfr_multibank_controller: RTL and testbench

- Next-generation frame-reader controller that programs the packet-reader slave (PRC) over an Avalon-MM write master, one video frame at a time.
- Selects from NUM_BANKS frame-buffer banks instead of two.
- Honours master waitrequest, and supports one-shot and continuous modes.
- Adds a watchdog that aborts a hung frame. Sits between the VFR slave register file and the PRC/control-packet encoder.

---
 rtl/vfr_ctrl_pkg.sv | 32 +++
 rtl/vfr_multibank_controller_bank_select.sv | 59 +++++
 rtl/vfr_multibank_controller.sv | 205 ++++++++++++++++++++
 tb/tb_vfr_multibank_controller.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfr_ctrl_pkg.sv
// Shared definitions for the multi-bank frame-reader controller:
// PRC register map, write payloads and the sequencing state type.
package vfr_ctrl_pkg;

    localparam logic [31:0] REG_GO        = 32'd0;
    localparam logic [31:0] REG_INTERRUPT = 32'd2;
    localparam logic [31:0] REG_ADDRESS   = 32'd3;
    localparam logic [31:0] REG_TYPE      = 32'd4;
    localparam logic [31:0] REG_SAMPLES   = 32'd5;
    localparam logic [31:0] REG_WORDS     = 32'd6;

    // GO register payloads: bit0 = go, bit1 = interrupt enable
    localparam logic [31:0] GO_WITH_IRQ = 32'd3;
    localparam logic [31:0] PRC_STOP    = 32'd0;
    localparam logic [31:0] IRQ_CLEAR   = 32'd2;
    localparam logic [31:0] TYPE_VIDEO  = 32'd0;

    typedef enum logic [3:0] {
        IDLE,
        LATCH,
        WR_ADDR,
        WR_SAMPLES,
        WR_WORDS,
        WR_TYPE,
        WR_GO,
        WAIT_IRQ,
        CLR_IRQ,
        ABORT_STOP,
        ABORT_CLR
    } state_t;

endpackage

// File: rtl/vfr_multibank_controller_bank_select.sv
// Registered per-bank field selector; out-of-range bank requests saturate
// to the last bank and the captured fields stay put until the next capture.
module vfr_bank_select #(
    parameter int NUM_BANKS        = 4,
    parameter int BANK_SEL_WIDTH   = 2,
    parameter int RES_WIDTH        = 16,
    parameter int INTERLACED_WIDTH = 4,
    parameter int ADDR_WIDTH       = 32,
    parameter int SAMPLES_WIDTH    = 32,
    parameter int WORDS_WIDTH      = 32
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   capture,
    input  logic [BANK_SEL_WIDTH-1:0]              next_bank,
    input  logic [NUM_BANKS*RES_WIDTH-1:0]         bank_width,
    input  logic [NUM_BANKS*RES_WIDTH-1:0]         bank_height,
    input  logic [NUM_BANKS*INTERLACED_WIDTH-1:0]  bank_interlaced,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0]        bank_base_address,
    input  logic [NUM_BANKS*SAMPLES_WIDTH-1:0]     bank_samples,
    input  logic [NUM_BANKS*WORDS_WIDTH-1:0]       bank_words,
    output logic [BANK_SEL_WIDTH-1:0]              bank,
    output logic [RES_WIDTH-1:0]                   width,
    output logic [RES_WIDTH-1:0]                   height,
    output logic [INTERLACED_WIDTH-1:0]            interlaced,
    output logic [ADDR_WIDTH-1:0]                  base_address,
    output logic [SAMPLES_WIDTH-1:0]               samples,
    output logic [WORDS_WIDTH-1:0]                 words
);

    logic [BANK_SEL_WIDTH-1:0] sel;

    always_comb begin
        sel = next_bank;
        if (int'(next_bank) >= NUM_BANKS)
            sel = BANK_SEL_WIDTH'(NUM_BANKS - 1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank         <= '0;
            width        <= '0;
            height       <= '0;
            interlaced   <= '0;
            base_address <= '0;
            samples      <= '0;
            words        <= '0;
        end else if (capture) begin
            bank         <= sel;
            width        <= bank_width[int'(sel)*RES_WIDTH +: RES_WIDTH];
            height       <= bank_height[int'(sel)*RES_WIDTH +: RES_WIDTH];
            interlaced   <= bank_interlaced[int'(sel)*INTERLACED_WIDTH +: INTERLACED_WIDTH];
            base_address <= bank_base_address[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
            samples      <= bank_samples[int'(sel)*SAMPLES_WIDTH +: SAMPLES_WIDTH];
            words        <= bank_words[int'(sel)*WORDS_WIDTH +: WORDS_WIDTH];
        end
    end

endmodule

// File: rtl/vfr_multibank_controller.sv
// Frame-reader controller: programs the PRC one frame at a time over an
// Avalon-MM write master, with bank selection, continuous mode and a watchdog.
module vfr_multibank_controller
    import vfr_ctrl_pkg::*;
#(
    parameter int NUM_BANKS        = 4,
    parameter int BANK_SEL_WIDTH   = 2,
    parameter int RES_WIDTH        = 16,
    parameter int INTERLACED_WIDTH = 4,
    parameter int ADDR_WIDTH       = 32,
    parameter int SAMPLES_WIDTH    = 32,
    parameter int WORDS_WIDTH      = 32,
    parameter int TIMEOUT_WIDTH    = 24
) (
    input  logic                                   clock,
    input  logic                                   reset,
    output logic [31:0]                            master_address,
    output logic                                   master_write,
    output logic [31:0]                            master_writedata,
    input  logic                                   master_waitrequest,
    input  logic                                   master_interrupt_receive,
    input  logic                                   go_bit,
    input  logic                                   continuous,
    input  logic [BANK_SEL_WIDTH-1:0]              next_bank,
    input  logic [TIMEOUT_WIDTH-1:0]               timeout_cycles,
    input  logic [NUM_BANKS*RES_WIDTH-1:0]         bank_width,
    input  logic [NUM_BANKS*RES_WIDTH-1:0]         bank_height,
    input  logic [NUM_BANKS*INTERLACED_WIDTH-1:0]  bank_interlaced,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0]        bank_base_address,
    input  logic [NUM_BANKS*SAMPLES_WIDTH-1:0]     bank_samples,
    input  logic [NUM_BANKS*WORDS_WIDTH-1:0]       bank_words,
    output logic                                   running,
    output logic                                   frame_complete,
    output logic                                   timeout_error,
    output logic [BANK_SEL_WIDTH-1:0]              current_bank,
    output logic [15:0]                            frame_count,
    output logic [RES_WIDTH-1:0]                   width_of_next_vid_packet,
    output logic [RES_WIDTH-1:0]                   height_of_next_vid_packet,
    output logic [INTERLACED_WIDTH-1:0]            interlaced_of_next_vid_packet,
    output logic                                   do_control_packet
);

    state_t                    state;
    logic [TIMEOUT_WIDTH-1:0]  watchdog;
    logic                      go_prev;
    logic                      capture;
    logic                      timeout_hit;
    logic [ADDR_WIDTH-1:0]     base_address;
    logic [SAMPLES_WIDTH-1:0]  samples;
    logic [WORDS_WIDTH-1:0]    words;

    // Bank fields are sampled exactly on the edge that enters LATCH
    assign capture = ((state == IDLE) && go_bit) ||
                     ((state == CLR_IRQ) && !master_waitrequest && continuous && go_bit);

    assign timeout_hit = (timeout_cycles != '0) &&
                         (watchdog == timeout_cycles - TIMEOUT_WIDTH'(1));

    vfr_bank_select #(
        .NUM_BANKS        (NUM_BANKS),
        .BANK_SEL_WIDTH   (BANK_SEL_WIDTH),
        .RES_WIDTH        (RES_WIDTH),
        .INTERLACED_WIDTH (INTERLACED_WIDTH),
        .ADDR_WIDTH       (ADDR_WIDTH),
        .SAMPLES_WIDTH    (SAMPLES_WIDTH),
        .WORDS_WIDTH      (WORDS_WIDTH)
    ) bank_select (
        .clock             (clock),
        .reset             (reset),
        .capture           (capture),
        .next_bank         (next_bank),
        .bank_width        (bank_width),
        .bank_height       (bank_height),
        .bank_interlaced   (bank_interlaced),
        .bank_base_address (bank_base_address),
        .bank_samples      (bank_samples),
        .bank_words        (bank_words),
        .bank              (current_bank),
        .width             (width_of_next_vid_packet),
        .height            (height_of_next_vid_packet),
        .interlaced        (interlaced_of_next_vid_packet),
        .base_address      (base_address),
        .samples           (samples),
        .words             (words)
    );

    // Each write state loads the following write only when the current one is accepted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            watchdog          <= '0;
            go_prev           <= 1'b0;
            master_address    <= '0;
            master_write      <= 1'b0;
            master_writedata  <= '0;
            running           <= 1'b0;
            frame_complete    <= 1'b0;
            timeout_error     <= 1'b0;
            frame_count       <= '0;
            do_control_packet <= 1'b0;
        end else begin
            go_prev           <= go_bit;
            frame_complete    <= 1'b0;
            do_control_packet <= 1'b0;
            if (go_bit && !go_prev)
                timeout_error <= 1'b0;

            case (state)
                IDLE: begin
                    if (go_bit) begin
                        state             <= LATCH;
                        do_control_packet <= 1'b1;
                    end
                end
                LATCH: begin
                    running          <= 1'b1;
                    master_write     <= 1'b1;
                    master_address   <= REG_ADDRESS;
                    master_writedata <= 32'(base_address);
                    state            <= WR_ADDR;
                end
                WR_ADDR: begin
                    if (!master_waitrequest) begin
                        master_address   <= REG_SAMPLES;
                        master_writedata <= 32'(samples);
                        state            <= WR_SAMPLES;
                    end
                end
                WR_SAMPLES: begin
                    if (!master_waitrequest) begin
                        master_address   <= REG_WORDS;
                        master_writedata <= 32'(words);
                        state            <= WR_WORDS;
                    end
                end
                WR_WORDS: begin
                    if (!master_waitrequest) begin
                        master_address   <= REG_TYPE;
                        master_writedata <= TYPE_VIDEO;
                        state            <= WR_TYPE;
                    end
                end
                WR_TYPE: begin
                    if (!master_waitrequest) begin
                        master_address   <= REG_GO;
                        master_writedata <= GO_WITH_IRQ;
                        state            <= WR_GO;
                    end
                end
                WR_GO: begin
                    if (!master_waitrequest) begin
                        master_write <= 1'b0;
                        watchdog     <= '0;
                        state        <= WAIT_IRQ;
                    end
                end
                WAIT_IRQ: begin
                    watchdog <= watchdog + TIMEOUT_WIDTH'(1);
                    if (master_interrupt_receive) begin
                        master_write     <= 1'b1;
                        master_address   <= REG_INTERRUPT;
                        master_writedata <= IRQ_CLEAR;
                        state            <= CLR_IRQ;
                    end else if (timeout_hit) begin
                        master_write     <= 1'b1;
                        master_address   <= REG_GO;
                        master_writedata <= PRC_STOP;
                        state            <= ABORT_STOP;
                    end
                end
                CLR_IRQ: begin
                    if (!master_waitrequest) begin
                        master_write   <= 1'b0;
                        frame_complete <= 1'b1;
                        frame_count    <= frame_count + 16'd1;
                        if (continuous && go_bit) begin
                            state             <= LATCH;
                            do_control_packet <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            running <= 1'b0;
                        end
                    end
                end
                ABORT_STOP: begin
                    if (!master_waitrequest) begin
                        master_address   <= REG_INTERRUPT;
                        master_writedata <= IRQ_CLEAR;
                        state            <= ABORT_CLR;
                    end
                end
                ABORT_CLR: begin
                    if (!master_waitrequest) begin
                        master_write  <= 1'b0;
                        timeout_error <= 1'b1;
                        running       <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vfr_multibank_controller.sv
// Scoreboard bench for vfr_multibank_controller: directed frames push expected
// PRC writes and encoder requests; a negedge monitor pops and compares them.
module tb_vfr_multibank_controller;

    localparam int NB  = 4;
    localparam int BSW = 3;
    localparam int RW  = 16;
    localparam int IW  = 4;
    localparam int AW  = 32;
    localparam int SW  = 32;
    localparam int WW  = 32;
    localparam int TW  = 24;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [31:0]          master_address;
    logic                 master_write;
    logic [31:0]          master_writedata;
    logic                 master_waitrequest;
    logic                 master_interrupt_receive;
    logic                 go_bit;
    logic                 continuous;
    logic [BSW-1:0]       next_bank;
    logic [TW-1:0]        timeout_cycles;
    logic [NB*RW-1:0]     bank_width;
    logic [NB*RW-1:0]     bank_height;
    logic [NB*IW-1:0]     bank_interlaced;
    logic [NB*AW-1:0]     bank_base_address;
    logic [NB*SW-1:0]     bank_samples;
    logic [NB*WW-1:0]     bank_words;
    logic                 running;
    logic                 frame_complete;
    logic                 timeout_error;
    logic [BSW-1:0]       current_bank;
    logic [15:0]          frame_count;
    logic [RW-1:0]        width_of_next_vid_packet;
    logic [RW-1:0]        height_of_next_vid_packet;
    logic [IW-1:0]        interlaced_of_next_vid_packet;
    logic                 do_control_packet;

    vfr_multibank_controller #(
        .NUM_BANKS(NB), .BANK_SEL_WIDTH(BSW), .RES_WIDTH(RW), .INTERLACED_WIDTH(IW),
        .ADDR_WIDTH(AW), .SAMPLES_WIDTH(SW), .WORDS_WIDTH(WW), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clock(clock), .reset(reset),
        .master_address(master_address), .master_write(master_write),
        .master_writedata(master_writedata), .master_waitrequest(master_waitrequest),
        .master_interrupt_receive(master_interrupt_receive),
        .go_bit(go_bit), .continuous(continuous), .next_bank(next_bank),
        .timeout_cycles(timeout_cycles),
        .bank_width(bank_width), .bank_height(bank_height),
        .bank_interlaced(bank_interlaced), .bank_base_address(bank_base_address),
        .bank_samples(bank_samples), .bank_words(bank_words),
        .running(running), .frame_complete(frame_complete),
        .timeout_error(timeout_error), .current_bank(current_bank),
        .frame_count(frame_count),
        .width_of_next_vid_packet(width_of_next_vid_packet),
        .height_of_next_vid_packet(height_of_next_vid_packet),
        .interlaced_of_next_vid_packet(interlaced_of_next_vid_packet),
        .do_control_packet(do_control_packet)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [15:0] w; logic [15:0] h; logic [3:0] il; logic [2:0] bank; } ctrl_t;

    wr_t   wr_q[$];
    ctrl_t ctrl_q[$];

    int   vectors      = 0;
    int   miscompares  = 0;
    int   fc_seen      = 0;
    int   dcp_seen     = 0;
    int   addr5_cycles = 0;
    logic expect_rearm = 1'b0;

    logic [15:0] tw    [NB] = '{16'd640, 16'd1280, 16'd1920, 16'd3840};
    logic [15:0] th    [NB] = '{16'd480, 16'd720, 16'd1080, 16'd2160};
    logic [3:0]  til   [NB] = '{4'h0, 4'h3, 4'h8, 4'hC};
    logic [31:0] tbase [NB] = '{32'h1000_0000, 32'h2000_4000, 32'h3000_8000, 32'h4000_C000};
    logic [31:0] tsamp [NB] = '{32'd307200, 32'd921600, 32'd2073600, 32'd8294400};
    logic [31:0] twrd  [NB] = '{32'd9600, 32'd28800, 32'd64800, 32'd259200};

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic flag_fail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got event, expected none", name);
    endtask

    // Monitor: every presented write must match the scoreboard head; pop on acceptance
    always @(negedge clock) begin
        wr_t   w;
        ctrl_t c;
        if (!reset) begin
            if (master_write) begin
                if (wr_q.size() == 0) begin
                    flag_fail("unexpected_write");
                end else begin
                    w = wr_q[0];
                    check_output("write_addr", master_address, w.addr);
                    check_output("write_data", master_writedata, w.data);
                    if (master_address == 32'd5) addr5_cycles++;
                    if (!master_waitrequest) void'(wr_q.pop_front());
                end
            end
            if (do_control_packet) begin
                dcp_seen++;
                if (ctrl_q.size() == 0) begin
                    flag_fail("unexpected_ctrl_packet");
                end else begin
                    c = ctrl_q.pop_front();
                    check_output("enc_width", width_of_next_vid_packet, c.w);
                    check_output("enc_height", height_of_next_vid_packet, c.h);
                    check_output("enc_interlaced", interlaced_of_next_vid_packet, c.il);
                    check_output("current_bank", current_bank, c.bank);
                end
            end
            if (frame_complete) begin
                fc_seen++;
                check_output("rearm_latch", do_control_packet, expect_rearm);
            end
        end
    end

    task automatic push_frame(input int b);
        wr_q.push_back('{32'd3, tbase[b]});
        wr_q.push_back('{32'd5, tsamp[b]});
        wr_q.push_back('{32'd6, twrd[b]});
        wr_q.push_back('{32'd4, 32'd0});
        wr_q.push_back('{32'd0, 32'd3});
        wr_q.push_back('{32'd2, 32'd2});
        ctrl_q.push_back('{tw[b], th[b], til[b], 3'(b)});
    endtask

    task automatic wait_writes_left(input int n);
        int budget = 400;
        while (wr_q.size() > n && budget > 0) begin
            @(negedge clock); #1;
            budget--;
        end
        if (wr_q.size() > n) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL write_wait: got %0d pending, expected %0d", wr_q.size(), n);
        end
    endtask

    task automatic apply_stimulus(input int irq_delay);
        wait_writes_left(1);
        repeat (irq_delay) @(negedge clock);
        master_interrupt_receive = 1'b1;
        wait_writes_left(0);
        master_interrupt_receive = 1'b0;
    endtask

    task automatic pulse_go();
        @(posedge clock); #1 go_bit = 1'b1;
        @(posedge clock); #1 go_bit = 1'b0;
    endtask

    task automatic check_reset_state();
        check_output("rst_master_write", master_write, 0);
        check_output("rst_master_address", master_address, 0);
        check_output("rst_master_writedata", master_writedata, 0);
        check_output("rst_running", running, 0);
        check_output("rst_frame_complete", frame_complete, 0);
        check_output("rst_timeout_error", timeout_error, 0);
        check_output("rst_current_bank", current_bank, 0);
        check_output("rst_frame_count", frame_count, 0);
        check_output("rst_width", width_of_next_vid_packet, 0);
        check_output("rst_height", height_of_next_vid_packet, 0);
        check_output("rst_interlaced", interlaced_of_next_vid_packet, 0);
        check_output("rst_do_control_packet", do_control_packet, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int idle;
        int budget;
        reset = 1'b1;
        master_waitrequest = 1'b0;
        master_interrupt_receive = 1'b0;
        go_bit = 1'b0;
        continuous = 1'b0;
        next_bank = '0;
        timeout_cycles = '0;
        for (int i = 0; i < NB; i++) begin
            bank_width[i*RW +: RW]        = tw[i];
            bank_height[i*RW +: RW]       = th[i];
            bank_interlaced[i*IW +: IW]   = til[i];
            bank_base_address[i*AW +: AW] = tbase[i];
            bank_samples[i*SW +: SW]      = tsamp[i];
            bank_words[i*WW +: WW]        = twrd[i];
        end
        repeat (2) @(negedge clock);
        check_reset_state();
        @(posedge clock); #1 reset = 1'b0;

        $display("[TB] one-shot frame on bank 2");
        next_bank = 3'd2;
        push_frame(2);
        pulse_go();
        apply_stimulus(10);
        repeat (3) @(negedge clock); #1;
        check_output("a_frame_count", frame_count, 1);
        check_output("a_running", running, 0);
        check_output("a_frame_complete_pulses", fc_seen, 1);

        $display("[TB] waitrequest stall on SAMPLES write");
        addr5_cycles = 0;
        push_frame(2);
        pulse_go();
        budget = 50;
        do begin
            @(posedge clock); #1;
            budget--;
        end while (!(master_write && master_address == 32'd5) && budget > 0);
        master_waitrequest = 1'b1;
        repeat (3) @(posedge clock);
        #1 master_waitrequest = 1'b0;
        apply_stimulus(5);
        repeat (3) @(negedge clock); #1;
        check_output("b_samples_hold_cycles", addr5_cycles, 4);
        check_output("b_frame_count", frame_count, 2);
        check_output("b_pending_writes", wr_q.size(), 0);

        $display("[TB] continuous mode alternating banks 0/3");
        continuous = 1'b1;
        next_bank = 3'd0;
        expect_rearm = 1'b1;
        push_frame(0);
        @(posedge clock); #1 go_bit = 1'b1;
        wait_writes_left(1);
        next_bank = 3'd3;
        repeat (4) @(negedge clock);
        master_interrupt_receive = 1'b1;
        wait_writes_left(0);
        master_interrupt_receive = 1'b0;
        push_frame(3);
        wait_writes_left(1);
        next_bank = 3'd0;
        repeat (2) @(negedge clock);
        master_interrupt_receive = 1'b1;
        wait_writes_left(0);
        master_interrupt_receive = 1'b0;
        push_frame(0);
        wait_writes_left(1);
        go_bit = 1'b0;
        expect_rearm = 1'b0;
        apply_stimulus(3);
        continuous = 1'b0;
        repeat (4) @(negedge clock); #1;
        check_output("c_frame_count", frame_count, 5);
        check_output("c_ctrl_packets", dcp_seen, 5);
        check_output("c_running", running, 0);

        $display("[TB] watchdog abort after 50 cycles");
        timeout_cycles = 24'd50;
        next_bank = 3'd1;
        push_frame(1);
        void'(wr_q.pop_back());
        wr_q.push_back('{32'd0, 32'd0});
        wr_q.push_back('{32'd2, 32'd2});
        pulse_go();
        wait_writes_left(2);
        idle = 0;
        budget = 200;
        while (budget > 0) begin
            @(negedge clock); #1;
            if (master_write) break;
            idle++;
            budget--;
        end
        check_output("d_wait_irq_cycles", idle, 50);
        wait_writes_left(0);
        repeat (3) @(negedge clock); #1;
        check_output("d_timeout_error", timeout_error, 1);
        check_output("d_running", running, 0);
        check_output("d_frame_count", frame_count, 5);
        check_output("d_frame_complete_pulses", fc_seen, 5);

        $display("[TB] saturated bank request, go clears timeout_error");
        timeout_cycles = '0;
        next_bank = 3'd7;
        push_frame(3);
        pulse_go();
        @(negedge clock); #1;
        check_output("e_timeout_error_cleared", timeout_error, 0);
        apply_stimulus(3);
        repeat (3) @(negedge clock); #1;
        check_output("e_frame_count", frame_count, 6);
        check_output("e_current_bank", current_bank, 3);

        $display("[TB] reset during stalled WORDS write");
        next_bank = 3'd1;
        push_frame(1);
        pulse_go();
        budget = 50;
        do begin
            @(posedge clock); #1;
            budget--;
        end while (!(master_write && master_address == 32'd6) && budget > 0);
        master_waitrequest = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock); #1;
        check_reset_state();
        wr_q.delete();
        ctrl_q.delete();
        fc_seen = 0;
        master_waitrequest = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        next_bank = 3'd2;
        push_frame(2);
        pulse_go();
        apply_stimulus(2);
        repeat (3) @(negedge clock); #1;
        check_output("f_frame_count", frame_count, 1);
        check_output("f_frame_complete_pulses", fc_seen, 1);
        check_output("f_running", running, 0);
        check_output("f_pending_writes", wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
